// File: rtl/branch_seq.sv
// branch_seq: sequences one conditional branch at a time through operand wait,
// comparator evaluation and a single-cycle resolve pulse, with resolve/taken counters.
`default_nettype none

module branch_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [2:0]  br_cmpop,
    input  logic [31:0] br_target,
    input  logic        rs_ready,
    input  logic        rt_ready,
    input  logic        flush,
    input  logic        judge,
    output logic [2:0]  cmp_op,
    output logic        stall,
    output logic        resolve_valid,
    output logic        resolve_taken,
    output logic [31:0] redirect_pc,
    output logic [15:0] br_cnt,
    output logic [15:0] taken_cnt,
    output logic        bds_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        EVAL    = 2'd2,
        RESOLVE = 2'd3
    } state_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] target_q, target_d;
    logic        taken_q, taken_d;
    logic [15:0] br_cnt_q, br_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic        bds_err_q, bds_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= 3'b000;
            target_q    <= 32'h0;
            taken_q     <= 1'b0;
            br_cnt_q    <= 16'h0;
            taken_cnt_q <= 16'h0;
            bds_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            target_q    <= target_d;
            taken_q     <= taken_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            bds_err_q   <= bds_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        target_d      = target_q;
        taken_d       = taken_q;
        stall         = 1'b0;
        cmp_op        = 3'b000;
        resolve_valid = 1'b0;
        case (state_q)
            IDLE: begin
                stall = br_valid;
                if (br_valid && !flush) begin
                    op_d     = br_cmpop;
                    target_d = br_target;
                    state_d  = (rs_ready && rt_ready) ? EVAL : WAIT;
                end
            end
            WAIT: begin
                stall  = 1'b1;
                cmp_op = op_q;
                if (flush) begin
                    state_d = IDLE;
                end else if (rs_ready && rt_ready) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                stall  = 1'b1;
                cmp_op = op_q;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    taken_d = judge;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                // flush wins over the resolve pulse
                resolve_valid = !flush;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resolve_taken = resolve_valid && taken_q;
    assign redirect_pc   = resolve_taken ? target_q : 32'h0;

    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (resolve_valid && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + 16'd1;
        end
        if (resolve_taken && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + 16'd1;
        end
    end

    // A branch showing up while resolving sits in the delay slot; flag it, never accept it.
    assign bds_err_d = bds_err_q || ((state_q == RESOLVE) && br_valid);

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
    assign bds_err   = bds_err_q;

endmodule

`default_nettype wire
